pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
- Synchronous flush inserts a bubble.
- Generic successor to the fixed-field M/W data register. The caller concatenates stage fields (ALUResult, ReadData, Rd, PCPlus4, …) into one DATA_W bus.
- Supports backpressure from downstream stalls and full throughput with no combinational ready path between stages.

Parameters:
- DATA_W, 32: width of in_data/out_data in bits (>=1).
- RESET_VAL, 0: value loaded into the data registers on reset, and on flush when CLEAR_ON_FLUSH=1; truncated to DATA_W.
- CLEAR_ON_FLUSH, 1: 1 = flush clears data registers to RESET_VAL; 0 = flush clears valid state only and data is held.
- CNT_W, 16: stall counter width; used only with PIPE_SKID_PERF_EN.

Ports:
- clk  input  1  clock, all state changes on the rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous bubble insert; discards all held entries
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept; registered output
- in_data  input  DATA_W  upstream entry payload
- out_valid  output  1  out_data holds a valid entry
- out_ready  input  1  downstream accepts
- out_data  output  DATA_W  payload; driven from the main register
- stall_cnt  output  CNT_W  present only with PIPE_SKID_PERF_EN

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage:
  - main register (drives out_data) and skid register.
  - FSM states: EMPTY (no entries), ONE (main valid), FULL (main and skid valid).
- Outputs: out_valid = (state != EMPTY); in_ready = (state != FULL), taken directly from the state flop. No combinational path from out_ready to in_ready.
- Reset: state=EMPTY, out_valid=0, in_ready=1, main=skid=RESET_VAL, stall_cnt=0. Reset takes effect immediately (asynchronous), including mid-transfer; in-flight entries are lost.
- Transitions (only when flush=0):
  - EMPTY: in_fire -> main<=in_data, go ONE. Otherwise stay.
  - ONE, in_fire & out_fire: main<=in_data, stay ONE (streaming, 1 entry/cycle).
  - ONE, in_fire & !out_fire: skid<=in_data, go FULL. in_ready=0 from the next cycle.
  - ONE, !in_fire & out_fire: go EMPTY. main holds its stale value.
  - FULL: in_ready=0, so no in_fire. out_fire -> main<=skid, go ONE. Otherwise hold.
- Flush:
  - Highest priority after reset. Next state = EMPTY.
  - An entry offered on in_fire in the same cycle is discarded.
  - An out_fire in the flush cycle still counts as consumed by downstream.
  - If CLEAR_ON_FLUSH=1, main and skid <= RESET_VAL; otherwise data is held.
- Latency: 1 cycle from in_fire (EMPTY or streaming) to out_valid/out_data.
- Throughput: 1 entry/cycle while out_ready=1.
- Ordering: strict FIFO; skid entry is always younger than main.
- Stability: while out_valid & !out_ready, out_data and out_valid hold unchanged (except on flush or reset).
- No entry is lost or duplicated: count(out_fire) = count(in_fire) - entries discarded by flush - entries held.

Optional Feature:
- PIPE_SKID_PERF_EN defined:
  - Port stall_cnt[CNT_W-1:0] exists.
  - Increments by 1 each cycle with out_valid & !out_ready; saturates at 2^CNT_W-1.
  - Cleared only by reset; unaffected by flush.
- PIPE_SKID_PERF_EN undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-operation: state FULL, assert reset asynchronously between edges -> out_valid=0, in_ready=1 and out_data=RESET_VAL immediately, with no clock edge required.
- Streaming: out_ready=1, in_data 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later, out_valid=1 for 3 cycles, in_ready stays 1.
- Backpressure fill: out_ready=0, send 0xA1 then 0xA2 -> state FULL, in_ready=0 on the third cycle, out_data holds 0xA1. Raise out_ready -> 0xA1 then 0xA2 emitted in order; in_ready returns to 1 after the first out_fire.
- Flush with CLEAR_ON_FLUSH=1: state FULL with 0xB1/0xB2, pulse flush with in_valid=1 and in_data=0xB3 -> next cycle out_valid=0, in_ready=1, out_data=0. 0xB3 is never output.
- Flush with CLEAR_ON_FLUSH=0: same sequence -> out_valid=0 and out_data still 0xB1. The next entry 0xC0 appears after 1 cycle.
- PIPE_SKID_PERF_EN with CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 (saturated). A flush leaves it at 15; reset returns it to 0.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with 2-entry skid buffer: 1-cycle latency, full throughput, and in_ready
// registered so there is no combinational path from out_ready. Defining PIPE_SKID_PERF_EN adds stall_cnt.
module pipe_skid_reg #(
    parameter int DATA_W         = 32,
    parameter     RESET_VAL      = 0,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    localparam logic [DATA_W-1:0] RST_DATA = DATA_W'(RESET_VAL);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_data = main_q;

    // out_valid and in_ready are kept as flops alongside the state so both
    // handshake outputs come straight from registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            main_q    <= RST_DATA;
            skid_q    <= RST_DATA;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            if (CLEAR_ON_FLUSH != 0) begin
                main_q <= RST_DATA;
                skid_q <= RST_DATA;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q    <= in_data;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q   <= in_data;
                        state    <= FULL;
                        in_ready <= 1'b0;
                    end else if (out_fire) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q   <= skid_q;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_PERF_EN
    // Saturating count of cycles a valid entry waits on downstream; flush does not clear it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench: two instances (flush clears data / flush holds data) driven with identical stimulus.
module tb_pipe_skid_reg;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       in_ready_c, out_valid_c;
    logic [7:0] out_data_c;
    logic       in_ready_h, out_valid_h;
    logic [7:0] out_data_h;
`ifdef PIPE_SKID_PERF_EN
    logic [3:0] stall_cnt_c;
    logic [3:0] stall_cnt_h;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    pipe_skid_reg #(.DATA_W(8), .RESET_VAL(0), .CLEAR_ON_FLUSH(1), .CNT_W(4)) dut_c (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c)
`ifdef PIPE_SKID_PERF_EN
        , .stall_cnt(stall_cnt_c)
`endif
    );

    pipe_skid_reg #(.DATA_W(8), .RESET_VAL(8'h5A), .CLEAR_ON_FLUSH(0), .CNT_W(4)) dut_h (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_h), .in_data(in_data),
        .out_valid(out_valid_h), .out_ready(out_ready), .out_data(out_data_h)
`ifdef PIPE_SKID_PERF_EN
        , .stall_cnt(stall_cnt_h)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        #12;
        chk("rst_valid_c", 32'(out_valid_c), 32'h0);
        chk("rst_ready_c", 32'(in_ready_c), 32'h1);
        chk("rst_data_c", 32'(out_data_c), 32'h00);
        chk("rst_data_h", 32'(out_data_h), 32'h5A);
        reset = 1'b0;

        // Streaming
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
        tick();
        chk("str1_valid", 32'(out_valid_c), 32'h1);
        chk("str1_data", 32'(out_data_c), 32'h11);
        chk("str1_ready", 32'(in_ready_c), 32'h1);
        in_data = 8'h22;
        tick();
        chk("str2_data", 32'(out_data_c), 32'h22);
        chk("str2_ready", 32'(in_ready_c), 32'h1);
        in_data = 8'h33;
        tick();
        chk("str3_valid", 32'(out_valid_c), 32'h1);
        chk("str3_data", 32'(out_data_h), 32'h33);
        in_valid = 1'b0;
        tick();
        chk("str_drain_valid", 32'(out_valid_c), 32'h0);

        // Backpressure fill and drain
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA1;
        tick();
        chk("bp1_ready", 32'(in_ready_c), 32'h1);
        chk("bp1_data", 32'(out_data_c), 32'hA1);
        in_data = 8'hA2;
        tick();
        chk("bp2_ready", 32'(in_ready_c), 32'h0);
        chk("bp2_data", 32'(out_data_c), 32'hA1);
        chk("bp2_valid", 32'(out_valid_c), 32'h1);
        in_valid = 1'b0;
        tick();
        chk("bp_hold_data", 32'(out_data_c), 32'hA1);
        chk("bp_hold_ready", 32'(in_ready_c), 32'h0);
        out_ready = 1'b1;
        tick();
        chk("bp_drain1_data", 32'(out_data_c), 32'hA2);
        chk("bp_drain1_ready", 32'(in_ready_c), 32'h1);
        chk("bp_drain1_valid", 32'(out_valid_c), 32'h1);
        tick();
        chk("bp_drain2_valid", 32'(out_valid_c), 32'h0);

        // Flush from FULL with an offered entry
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hB1;
        tick();
        in_data = 8'hB2;
        tick();
        chk("fl_full_ready", 32'(in_ready_h), 32'h0);
        flush = 1'b1; in_data = 8'hB3;
        tick();
        chk("fl_valid_c", 32'(out_valid_c), 32'h0);
        chk("fl_ready_c", 32'(in_ready_c), 32'h1);
        chk("fl_data_c", 32'(out_data_c), 32'h00);
        chk("fl_valid_h", 32'(out_valid_h), 32'h0);
        chk("fl_ready_h", 32'(in_ready_h), 32'h1);
        chk("fl_data_h", 32'(out_data_h), 32'hB1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("fl_after_valid_c", 32'(out_valid_c), 32'h0);
        chk("fl_after_valid_h", 32'(out_valid_h), 32'h0);
        in_valid = 1'b1; in_data = 8'hC0;
        tick();
        chk("fl_next_valid_h", 32'(out_valid_h), 32'h1);
        chk("fl_next_data_h", 32'(out_data_h), 32'hC0);
        chk("fl_next_data_c", 32'(out_data_c), 32'hC0);

        // Flush in ONE with a real in_fire: entry is discarded
        in_data = 8'hD0; flush = 1'b1;
        tick();
        chk("fl1_valid_c", 32'(out_valid_c), 32'h0);
        chk("fl1_data_h", 32'(out_data_h), 32'hC0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("fl1_after_valid_c", 32'(out_valid_c), 32'h0);
        chk("fl1_after_valid_h", 32'(out_valid_h), 32'h0);

        // Asynchronous reset from FULL, between edges
        in_valid = 1'b1; in_data = 8'hE1;
        tick();
        in_data = 8'hE2;
        tick();
        chk("ar_full_ready", 32'(in_ready_c), 32'h0);
        in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("ar_valid_c", 32'(out_valid_c), 32'h0);
        chk("ar_ready_c", 32'(in_ready_c), 32'h1);
        chk("ar_data_c", 32'(out_data_c), 32'h00);
        chk("ar_valid_h", 32'(out_valid_h), 32'h0);
        chk("ar_data_h", 32'(out_data_h), 32'h5A);
        reset = 1'b0;
        tick();
        chk("ar_post_valid", 32'(out_valid_h), 32'h0);

`ifdef PIPE_SKID_PERF_EN
        chk("perf_rst", 32'(stall_cnt_c), 32'h0);
        in_valid = 1'b1; in_data = 8'hF1;
        tick();
        in_valid = 1'b0;
        chk("perf_start", 32'(stall_cnt_c), 32'h0);
        for (int i = 0; i < 5; i++) tick();
        chk("perf_5", 32'(stall_cnt_c), 32'h5);
        for (int i = 0; i < 15; i++) tick();
        chk("perf_sat", 32'(stall_cnt_c), 32'hF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("perf_flush", 32'(stall_cnt_c), 32'hF);
        tick();
        chk("perf_flush2", 32'(stall_cnt_h), 32'hF);
        #2;
        reset = 1'b1;
        #1;
        chk("perf_reset", 32'(stall_cnt_c), 32'h0);
        reset = 1'b0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
